// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter: shares the game work-RAM port between the Z80 and the hiscore engine.
// Define HS_ARB_WRITE_GUARD_EN to confine hiscore writes to GUARD_LO..GUARD_HI and count blocked writes.
module hs_ram_arbiter #(
   parameter int AW             = 16,
   parameter int SETTLE         = 4,
   parameter int RELEASE_CYCLES = 2
`ifdef HS_ARB_WRITE_GUARD_EN
   ,
   parameter logic [AW-1:0] GUARD_LO = 16'h6000,
   parameter logic [AW-1:0] GUARD_HI = 16'h67FF
`endif
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          pause_req,
   input  logic          cpu_idle,
   output logic          cpu_hold,
   input  logic [AW-1:0] cpu_addr,
   input  logic          cpu_we,
   input  logic [7:0]    cpu_din,
   input  logic [AW-1:0] hs_address,
   input  logic [7:0]    hs_data_in,
   input  logic          hs_write_enable,
   input  logic          hs_read_intent,
   input  logic          hs_write_intent,
   output logic [7:0]    hs_data_out,
   output logic          hs_grant,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [7:0]    ram_din,
   input  logic [7:0]    ram_dout
`ifdef HS_ARB_WRITE_GUARD_EN
   ,
   output logic [7:0]    guard_blocked
`endif
);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] DRAIN   = 2'd1;
   localparam logic [1:0] GRANT   = 2'd2;
   localparam logic [1:0] RELEASE = 2'd3;
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
   localparam logic [3:0] REL_LAST    = 4'(RELEASE_CYCLES - 1);
   logic [1:0] state, next_state;
   logic [3:0] cnt, cnt_next, cnt_inc;
   logic       intent, hs_sel, hs_we_ok;
   assign intent  = hs_read_intent | hs_write_intent;
   assign cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;
   assign hs_sel  = state == GRANT;
   always_comb begin
      next_state = state;
      cnt_next   = 4'd0;
      unique case (state)
         IDLE:  next_state = intent ? DRAIN : IDLE;
         DRAIN: begin
            next_state = !intent ? RELEASE : (cpu_idle && cnt == SETTLE_LAST) ? GRANT : DRAIN;
            cnt_next   = (next_state == DRAIN && cpu_idle) ? cnt_inc : 4'd0;
         end
         GRANT: next_state = intent ? GRANT : RELEASE;
         RELEASE: begin
            next_state = (cnt == REL_LAST) ? IDLE : RELEASE;
            cnt_next   = cnt_inc;
         end
      endcase
   end
`ifdef HS_ARB_WRITE_GUARD_EN
   logic in_win;
   assign in_win   = hs_address >= GUARD_LO && hs_address <= GUARD_HI;
   assign hs_we_ok = hs_write_enable & in_win;
   always_ff @(posedge clk_sys) begin
      if (reset)
         guard_blocked <= 8'd0;
      else if (hs_sel && hs_write_enable && !in_win && guard_blocked != 8'hFF)
         guard_blocked <= guard_blocked + 8'd1;
   end
`else
   assign hs_we_ok = hs_write_enable;
`endif
   // CPU writes are swallowed while the port is handed back, so a stalled strobe cannot land late
   assign ram_addr = hs_sel ? hs_address : cpu_addr;
   assign ram_din  = hs_sel ? hs_data_in : cpu_din;
   assign ram_we   = hs_sel ? hs_we_ok : (state != RELEASE) & cpu_we;
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         cpu_hold    <= 1'b0;
         hs_grant    <= 1'b0;
         hs_data_out <= 8'd0;
      end else begin
         state    <= next_state;
         cnt      <= cnt_next;
         cpu_hold <= pause_req | (next_state != IDLE);
         hs_grant <= next_state == GRANT;
         if (hs_sel)
            hs_data_out <= ram_dout;
      end
   end
endmodule

// File: doc/hs_ram_arbiter.md
Name: hs_ram_arbiter

Overview:
- Shares the game work-RAM port between the Z80 CPU and the hiscore dump/restore engine.
- On a hiscore access intent: holds the CPU, waits for the bus to settle, grants the RAM port to the hiscore engine, then hands the port back.
- Merges the user/OSD pause request into the same CPU hold.
- Sits between the top level (hiscore, pause) and the bagman core RAM port.

Parameters:
- AW, 16, RAM address width.
- SETTLE, 4, consecutive cpu_idle cycles required before grant (1..15).
- RELEASE_CYCLES, 2, cycles the hold is kept after the port returns to the CPU (1..15).
- GUARD_LO, 16'h6000, lowest address hiscore may write (guard feature only).
- GUARD_HI, 16'h67FF, highest address hiscore may write (guard feature only).

Ports:
- clk_sys  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- pause_req  in  1  pause request from the pause block.
- cpu_idle  in  1  CPU at a safe bus boundary (no memory cycle in flight).
- cpu_hold  out  1  registered hold/pause to the CPU.
- cpu_addr  in  AW  CPU RAM address.
- cpu_we  in  1  CPU RAM write strobe.
- cpu_din  in  8  CPU write data.
- hs_address  in  AW  hiscore RAM address.
- hs_data_in  in  8  hiscore write data.
- hs_write_enable  in  1  hiscore write strobe.
- hs_read_intent  in  1  hiscore wants read access.
- hs_write_intent  in  1  hiscore wants write access.
- hs_data_out  out  8  registered RAM read data to hiscore.
- hs_grant  out  1  registered; port owned by hiscore.
- ram_addr  out  AW  muxed RAM address.
- ram_we  out  1  muxed RAM write enable.
- ram_din  out  8  muxed RAM write data.
- ram_dout  in  8  RAM read data (1-cycle synchronous read).

Behaviour:
- Reset: state=IDLE; cpu_hold=0, hs_grant=0, hs_data_out=0, counters=0. Reset mid-grant aborts immediately; next cycle the mux selects the CPU.
- FSM states: IDLE, DRAIN, GRANT, RELEASE.
- IDLE:
  - mux=CPU.
  - intent = hs_read_intent | hs_write_intent; if intent -> DRAIN, cnt=0.
- DRAIN:
  - mux=CPU; CPU writes still pass.
  - cpu_idle=1: cnt++; cpu_idle=0: cnt=0.
  - cpu_idle=1 with cnt==SETTLE-1 -> GRANT.
  - Intent dropped before grant -> RELEASE.
- GRANT:
  - mux=hiscore: ram_addr=hs_address, ram_din=hs_data_in, ram_we=hs_write_enable.
  - hs_data_out <= ram_dout every cycle. Read data is valid on hs_data_out 2 clocks after hs_address is presented.
  - Both intents low -> RELEASE, cnt=0.
- RELEASE:
  - mux=CPU; cpu_we is forced to 0.
  - cnt++; at cnt==RELEASE_CYCLES-1 -> IDLE.
  - Intents arriving during RELEASE are ignored until IDLE; re-entry into DRAIN happens from IDLE next cycle.
- Outputs:
  - cpu_hold <= pause_req | (next_state != IDLE). First DRAIN cycle therefore has cpu_hold=1.
  - hs_grant <= (next_state == GRANT).
- pause_req toggling in any state never changes the FSM; while the FSM is non-IDLE, cpu_hold stays 1 regardless of pause_req.
- Write-strobe gating: hs_write_enable outside GRANT never reaches the RAM; cpu_we in GRANT/RELEASE never reaches the RAM.
- Counters are 4-bit and saturate, no wrap.

Optional Feature:
- Macro: HS_ARB_WRITE_GUARD_EN.
- Defined: in GRANT, ram_we = hs_write_enable & (GUARD_LO <= hs_address <= GUARD_HI).
  - Each blocked write increments an 8-bit saturating counter, output guard_blocked (8, out, reset 0).
  - The port exists only when the macro is defined.
- Undefined: no address check; no guard_blocked port.

Test Plan:
- Reset, then idle 10 cycles -> cpu_hold=0, hs_grant=0, ram_addr tracks cpu_addr, ram_we=cpu_we.
- hs_read_intent=1, cpu_idle=1 steady, SETTLE=4 -> cpu_hold=1 one cycle later; hs_grant=1 5 cycles after intent. RAM[0x6010]=0xA5 read at hs_address 0x6010 -> hs_data_out=0xA5 two cycles after address.
- In DRAIN, cpu_idle pattern 1,1,0,1,1,1,1 -> grant only after the final 4 consecutive idles. A CPU write of 0x3C to 0x6000 during DRAIN is written to RAM.
- In GRANT, hs_write_intent, hs_address=0x6020, hs_data_in=0x5A, hs_write_enable=1; cpu_we=1 at 0x6020 with 0x11 -> RAM holds 0x5A.
- Intents drop -> hs_grant=0 next cycle; cpu_hold stays 1 for RELEASE_CYCLES=2, then 0. With pause_req=1 held, cpu_hold stays 1 throughout.
- Reset asserted mid-GRANT -> next cycle hs_grant=0, cpu_hold=0, ram_addr=cpu_addr. With HS_ARB_WRITE_GUARD_EN, a write to 0x7000 is dropped and guard_blocked=1.
